// File: rtl/rpn_stack.sv
// Operand stack for the RPN calculator: top two entries held in registers for
// zero-latency ALU access, deeper entries kept in an array behind them.
module rpn_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  localparam int SIZE_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd,
  input  logic [WIDTH-1:0]  in_num,
  output logic [SIZE_W-1:0] size,
  output logic [WIDTH-1:0]  top,
  output logic [WIDTH-1:0]  next,
  output logic              full,
  output logic              empty,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_DUP   = 3'd3,
    OP_SWAP  = 3'd4,
    OP_REPL2 = 3'd5,
    OP_CLEAR = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_OVER  = 2'd1;
  localparam logic [1:0] ERR_UNDER = 2'd2;
  localparam logic [1:0] ERR_ILL   = 2'd3;

  logic [SIZE_W-1:0] size_q, size_d;
  logic [WIDTH-1:0]  top_q, top_d;
  logic [WIDTH-1:0]  next_q, next_d;
  logic [1:0]        err_q, err_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              error_q, error_d;

  // Entry at stack position p lives in mem[p]; only positions 0..size-3 are meaningful.
  logic [WIDTH-1:0]  mem [0:DEPTH-1];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [WIDTH-1:0]  deep;

  logic is_full, has1, has2, has3;

  always_comb begin
    is_full   = (size_q == SIZE_W'(DEPTH));
    has1      = (size_q != '0);
    has2      = (size_q >= SIZE_W'(2));
    has3      = (size_q >= SIZE_W'(3));
    mem_raddr = ADDR_W'(size_q - SIZE_W'(3));
    mem_waddr = ADDR_W'(size_q - SIZE_W'(2));
    deep      = has3 ? mem[mem_raddr] : '0;

    size_d = size_q;
    top_d  = top_q;
    next_d = next_q;
    err_d  = err_q;
    mem_we = 1'b0;

    if (cmd_valid) begin
      case (cmd)
        OP_NOP: ;
        OP_PUSH: begin
          if (is_full) begin
            err_d = ERR_OVER;
          end else begin
            top_d  = in_num;
            next_d = top_q;
            size_d = size_q + SIZE_W'(1);
            mem_we = has2;
            err_d  = ERR_NONE;
          end
        end
        OP_POP: begin
          if (!has1) begin
            err_d = ERR_UNDER;
          end else begin
            top_d  = next_q;
            next_d = deep;
            size_d = size_q - SIZE_W'(1);
            err_d  = ERR_NONE;
          end
        end
        OP_DUP: begin
          if (is_full) begin
            err_d = ERR_OVER;
          end else if (!has1) begin
            err_d = ERR_UNDER;
          end else begin
            next_d = top_q;
            size_d = size_q + SIZE_W'(1);
            mem_we = has2;
            err_d  = ERR_NONE;
          end
        end
        OP_SWAP: begin
          if (!has2) begin
            err_d = ERR_UNDER;
          end else begin
            top_d  = next_q;
            next_d = top_q;
            err_d  = ERR_NONE;
          end
        end
        OP_REPL2: begin
          if (!has2) begin
            err_d = ERR_UNDER;
          end else begin
            top_d  = in_num;
            next_d = deep;
            size_d = size_q - SIZE_W'(1);
            err_d  = ERR_NONE;
          end
        end
        OP_CLEAR: begin
          size_d = '0;
          top_d  = '0;
          next_d = '0;
          err_d  = ERR_NONE;
        end
        default: err_d = ERR_ILL;
      endcase
    end

    full_d  = (size_d == SIZE_W'(DEPTH));
    empty_d = (size_d == '0);
    error_d = (err_d != ERR_NONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q  <= '0;
      top_q   <= '0;
      next_q  <= '0;
      err_q   <= ERR_NONE;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      size_q  <= size_d;
      top_q   <= top_d;
      next_q  <= next_d;
      err_q   <= err_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      error_q <= error_d;
    end
  end

  // On a push the old next spills into the array; it is never visible below size.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= next_q;
  end

  assign size     = size_q;
  assign top      = top_q;
  assign next     = next_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign error    = error_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_rpn_stack.sv
// Directed bench for rpn_stack at WIDTH=32, DEPTH=4.
module tb_rpn_stack;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int SIZE_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [WIDTH-1:0]  in_num;
  logic [SIZE_W-1:0] size;
  logic [WIDTH-1:0]  top;
  logic [WIDTH-1:0]  next;
  logic              full;
  logic              empty;
  logic              error;
  logic [1:0]        err_code;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                         SWAP = 3'd4, REPL2 = 3'd5, CLEAR = 3'd6, RSVD = 3'd7;

  rpn_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .in_num(in_num),
    .size(size), .top(top), .next(next), .full(full), .empty(empty),
    .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [31:0] v, input logic vld = 1'b1);
    @(negedge clk);
    cmd_valid = vld;
    cmd       = c;
    in_num    = v;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd = NOP; in_num = '0;
    #1;
    chk("rst_size", 32'(size), 0);
    chk("rst_top", top, 0);
    chk("rst_next", next, 0);
    chk("rst_err", 32'(err_code), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    #20 reset = 1'b0;

    // Scenario 1: three pushes
    do_cmd(PUSH, 5); do_cmd(PUSH, 7); do_cmd(PUSH, 9);
    chk("s1_size", 32'(size), 3);
    chk("s1_top", top, 9);
    chk("s1_next", next, 7);
    chk("s1_error", 32'(error), 0);
    chk("s1_empty", 32'(empty), 0);

    // Scenario 2: swap then binary-op writeback
    do_cmd(SWAP, 0);
    chk("s2_swap_top", top, 7);
    chk("s2_swap_next", next, 9);
    do_cmd(REPL2, 16);
    chk("s2_repl_size", 32'(size), 2);
    chk("s2_repl_top", top, 16);
    chk("s2_repl_next", next, 5);
    chk("s2_repl_err", 32'(err_code), 0);

    // Scenario 3: overflow
    do_cmd(CLEAR, 0);
    for (int i = 1; i <= 4; i++) do_cmd(PUSH, 32'(i));
    chk("s3_fill_full", 32'(full), 1);
    chk("s3_fill_next", next, 3);
    do_cmd(PUSH, 99);
    chk("s3_ovf_err", 32'(err_code), 1);
    chk("s3_ovf_error", 32'(error), 1);
    chk("s3_ovf_full", 32'(full), 1);
    chk("s3_ovf_top", top, 4);
    chk("s3_ovf_size", 32'(size), 4);
    do_cmd(DUP, 0);
    chk("s3_dup_err", 32'(err_code), 1);
    chk("s3_dup_size", 32'(size), 4);
    do_cmd(POP, 0);
    chk("s3_pop_err", 32'(err_code), 0);
    chk("s3_pop_top", top, 3);
    chk("s3_pop_next", next, 2);
    chk("s3_pop_size", 32'(size), 3);
    chk("s3_pop_full", 32'(full), 0);

    // Scenario 4: underflow and illegal op
    pulse_reset();
    do_cmd(POP, 0);
    chk("s4_pop_err", 32'(err_code), 2);
    chk("s4_pop_size", 32'(size), 0);
    chk("s4_pop_top", top, 0);
    do_cmd(PUSH, 8);
    chk("s4_push_err", 32'(err_code), 0);
    do_cmd(SWAP, 0);
    chk("s4_swap_err", 32'(err_code), 2);
    chk("s4_swap_top", top, 8);
    do_cmd(REPL2, 44);
    chk("s4_repl_err", 32'(err_code), 2);
    chk("s4_repl_top", top, 8);
    do_cmd(RSVD, 0);
    chk("s4_ill_err", 32'(err_code), 3);
    do_cmd(NOP, 0);
    chk("s4_nop_err", 32'(err_code), 3);
    do_cmd(PUSH, 77, 1'b0);
    chk("s4_novalid_size", 32'(size), 1);
    chk("s4_novalid_top", top, 8);
    chk("s4_novalid_err", 32'(err_code), 3);

    // Scenario 5: all-ones operand through dup and pops
    do_cmd(CLEAR, 0);
    do_cmd(PUSH, 32'hFFFF_FFFF);
    chk("s5_push_top", top, 32'hFFFF_FFFF);
    chk("s5_push_next", next, 0);
    do_cmd(DUP, 0);
    chk("s5_dup_top", top, 32'hFFFF_FFFF);
    chk("s5_dup_next", next, 32'hFFFF_FFFF);
    chk("s5_dup_size", 32'(size), 2);
    do_cmd(POP, 0);
    chk("s5_pop1_top", top, 32'hFFFF_FFFF);
    chk("s5_pop1_next", next, 0);
    do_cmd(POP, 0);
    chk("s5_pop2_top", top, 0);
    chk("s5_pop2_next", next, 0);
    chk("s5_pop2_empty", 32'(empty), 1);

    // Scenario 6: asynchronous reset between edges, then CLEAR
    do_cmd(PUSH, 1); do_cmd(PUSH, 2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("s6_arst_size", 32'(size), 0);
    chk("s6_arst_top", top, 0);
    chk("s6_arst_next", next, 0);
    chk("s6_arst_empty", 32'(empty), 1);
    #1 reset = 1'b0;
    do_cmd(PUSH, 10); do_cmd(PUSH, 20); do_cmd(PUSH, 30);
    do_cmd(RSVD, 0);
    chk("s6_pre_error", 32'(error), 1);
    do_cmd(CLEAR, 0);
    chk("s6_clr_size", 32'(size), 0);
    chk("s6_clr_top", top, 0);
    chk("s6_clr_next", next, 0);
    chk("s6_clr_error", 32'(error), 0);
    chk("s6_clr_empty", 32'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
